// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of one shared LIFO stack. Arbitration is round-robin
// with an optional ownership lock, and every completed operation returns a registered one-cycle pulse.
module stack_arbiter #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0,
   input  logic                   req1,
   input  logic                   op0,
   input  logic                   op1,
   input  logic [W-1:0]           wdata0,
   input  logic [W-1:0]           wdata1,
   input  logic                   lock0,
   input  logic                   lock1,
   input  logic                   flush,
   output logic                   gnt0,
   output logic                   gnt1,
   output logic                   err,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          last_gnt;   // 1 = requester 1 was granted most recently
   logic [CW-1:0] sp;
   logic [W-1:0]  mem [DEPTH];

   logic          elig0;
   logic          elig1;
   logic          grant0;
   logic          grant1;
   logic          any_grant;
   logic          sel_op;
   logic [W-1:0]  sel_data;
   logic          is_full;
   logic          is_empty;
   logic          do_push;
   logic          do_pop;
   logic          op_err;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;

   // A requester whose grant pulse is still visible sits out this cycle.
   assign elig0 = req0 & ~gnt0;
   assign elig1 = req1 & ~gnt1;

   assign is_full  = (sp == CW'(DEPTH));
   assign is_empty = (sp == '0);

   // ---------------------------------------------------------------------------
   // FSM process 1: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FREE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = FREE;
      end else if (grant0) begin
         state_next = lock0 ? OWN0 : FREE;
      end else if (grant1) begin
         state_next = lock1 ? OWN1 : FREE;
      end else begin
         unique case (state)
            OWN0:    if (!lock0) state_next = FREE;
            OWN1:    if (!lock1) state_next = FREE;
            FREE:    state_next = FREE;
            default: state_next = FREE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 3: grant decision (the state machine's outputs)
   // ---------------------------------------------------------------------------
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!flush) begin
         unique case (state)
            FREE: begin
               if (elig0 && elig1) begin
                  grant0 = last_gnt;
                  grant1 = ~last_gnt;
               end else begin
                  grant0 = elig0;
                  grant1 = elig1;
               end
            end
            OWN0:    grant0 = elig0;
            OWN1:    grant1 = elig1;
            default: begin
               grant0 = 1'b0;
               grant1 = 1'b0;
            end
         endcase
      end
   end

   // The winning request's operation and data.
   assign any_grant = grant0 | grant1;
   assign sel_op    = grant0 ? op0 : op1;
   assign sel_data  = grant0 ? wdata0 : wdata1;

   assign do_push = any_grant &  sel_op & ~is_full;
   assign do_pop  = any_grant & ~sel_op & ~is_empty;
   assign op_err  = any_grant & (sel_op ? is_full : is_empty);

   assign wr_idx  = sp[AW-1:0];
   assign top_idx = sp[AW-1:0] - AW'(1);

   // ---------------------------------------------------------------------------
   // Pointer, arbitration history and registered response
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sp       <= '0;
         last_gnt <= 1'b1;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
      end else begin
         gnt0  <= grant0;
         gnt1  <= grant1;
         err   <= op_err;
         rdata <= do_pop ? mem[top_idx] : '0;
         if (any_grant) begin
            last_gnt <= grant1;
         end
         if (flush) begin
            sp <= '0;
         end else if (do_push) begin
            sp <= sp + CW'(1);
         end else if (do_pop) begin
            sp <= sp - CW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stack storage
   // ---------------------------------------------------------------------------
   // NOTE: the memory array has no reset. Only the pointer is cleared, and
   // entries above the pointer are never read until they are overwritten.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem[wr_idx] <= sel_data;
      end
   end

   assign count = sp;
   assign full  = is_full;
   assign empty = is_empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter. A queue-based reference model runs
// alongside the DUT, with directed scenarios first and randomized traffic after.
module tb_stack_arbiter;

   localparam int DEPTH = 16;
   localparam int W     = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0;
   logic          req1;
   logic          op0;
   logic          op1;
   logic [W-1:0]  wdata0;
   logic [W-1:0]  wdata1;
   logic          lock0;
   logic          lock1;
   logic          flush;
   logic          gnt0;
   logic          gnt1;
   logic          err;
   logic [W-1:0]  rdata;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   int    checks = 0;
   int    errors = 0;
   string phase  = "init";

   // Reference model: the stack as a queue, the owner (-1 means no owner),
   // the last winner, and the grant pulses the model currently expects to be visible.
   int stk[$];
   int owner    = -1;
   int last_win = 1;
   bit pg0      = 1'b0;
   bit pg1      = 1'b0;

   stack_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .req1   (req1),
      .op0    (op0),
      .op1    (op1),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .lock0  (lock0),
      .lock1  (lock1),
      .flush  (flush),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .err    (err),
      .rdata  (rdata),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, predict the response, and then compare it after the edge.
   task automatic cycle(input bit r, input bit f,
                        input bit q0, input bit o0, input bit l0, input logic [W-1:0] d0,
                        input bit q1, input bit o1, input bit l1, input logic [W-1:0] d1);
      int w;
      bit e0, e1, op, lk, xg0, xg1, xerr;
      int xrd;
      logic [W-1:0] dat;
      rst = r;  flush = f;
      req0 = q0; op0 = o0; lock0 = l0; wdata0 = d0;
      req1 = q1; op1 = o1; lock1 = l1; wdata1 = d1;
      xg0 = 1'b0; xg1 = 1'b0; xerr = 1'b0; xrd = 0; w = -1;
      if (r) begin
         stk.delete();
         owner    = -1;
         last_win = 1;
      end else if (f) begin
         stk.delete();
         owner = -1;
      end else begin
         e0 = q0 && !pg0;
         e1 = q1 && !pg1;
         if (owner == 0)      w = e0 ? 0 : -1;
         else if (owner == 1) w = e1 ? 1 : -1;
         else if (e0 && e1)   w = (last_win == 1) ? 0 : 1;
         else if (e0)         w = 0;
         else if (e1)         w = 1;
         if (w >= 0) begin
            op  = (w == 0) ? o0 : o1;
            dat = (w == 0) ? d0 : d1;
            lk  = (w == 0) ? l0 : l1;
            last_win = w;
            if (op) begin
               if (stk.size() == DEPTH) xerr = 1'b1;
               else stk.push_back(int'(dat));
            end else begin
               if (stk.size() == 0) xerr = 1'b1;
               else xrd = stk.pop_back();
            end
            owner = lk ? w : -1;
            xg0 = (w == 0);
            xg1 = (w == 1);
         end else if (owner == 0 && !l0) begin
            owner = -1;
         end else if (owner == 1 && !l1) begin
            owner = -1;
         end
      end
      pg0 = xg0;
      pg1 = xg1;
      @(posedge clk);
      #1;
      check("gnt0", gnt0, xg0);
      check("gnt1", gnt1, xg1);
      check("excl", gnt0 & gnt1, 0);
      check("err", err, xerr);
      if (xg0 || xg1 || r) check("rdata", rdata, xrd);
      check("count", count, stk.size());
      check("full", full, stk.size() == DEPTH);
      check("empty", empty, stk.size() == 0);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, '0, 0, 0, 0, '0);
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0, 0, '0, 0, 0, 0, '0);
      cycle(1, 0, 0, 0, 0, '0, 0, 0, 0, '0);
   endtask

   initial begin
      bit seen;
      bit push_bias;
      bit rq0, rq1, po0, po1, lk0, lk1, rr, ff;

      phase = "reset";
      do_reset();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_rdata", rdata, 0);

      // Push 0x05, then pop it back with requester 0.
      phase = "push_pop";
      cycle(0, 0, 1, 1, 0, 8'h05, 0, 0, 0, '0);
      check("g_c2", gnt0, 1);
      idle();
      cycle(0, 0, 1, 0, 0, '0, 0, 0, 0, '0);
      check("g_c4", gnt0, 1);
      check("rd_05", rdata, 8'h05);
      check("cnt0", count, 0);

      // A pop on an empty stack reports an underflow.
      phase = "underflow";
      idle();
      cycle(0, 0, 0, 0, 0, '0, 1, 0, 0, '0);
      check("uf_gnt1", gnt1, 1);
      check("uf_err", err, 1);
      check("uf_rdata", rdata, 0);
      check("uf_count", count, 0);

      // Both requesters push continuously: grants alternate, and the 17th push overflows.
      phase = "fill";
      do_reset();
      for (int i = 0; i < 17; i++) begin
         cycle(0, 0, 1, 1, 0, W'(i), 1, 1, 0, W'(8'h80 + i));
         check("alt0", gnt0, (i % 2) == 0);
         check("alt1", gnt1, (i % 2) == 1);
         if (i == 15) check("full16", full, 1);
      end
      check("ovf_err", err, 1);
      check("ovf_count", count, 16);

      // Requester 0 holds the lock, so requester 1 stays blocked until the lock drops.
      phase = "lock";
      do_reset();
      cycle(0, 0, 1, 1, 1, 8'h11, 1, 1, 0, 8'hAA);
      check("l_g1_a", gnt1, 0);
      cycle(0, 0, 1, 1, 1, 8'h22, 1, 1, 0, 8'hAA);
      check("l_g1_b", gnt1, 0);
      cycle(0, 0, 1, 1, 1, 8'h22, 1, 1, 0, 8'hAA);
      check("l_g1_c", gnt1, 0);
      check("l_cnt2", count, 2);
      cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 8'hAA);
      check("l_g1_d", gnt1, 0);
      seen = 1'b0;
      for (int k = 0; k < 2 && !seen; k++) begin
         cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 8'hAA);
         if (gnt1) seen = 1'b1;
      end
      check("l_g1_within2", seen, 1);

      // A flush clears the stack and suppresses the grant; requester 1 is granted next.
      phase = "flush";
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 1, 0, W'(8'h30 + i), 0, 0, 0, '0);
         idle();
      end
      check("f_cnt3", count, 3);
      cycle(0, 1, 0, 0, 0, '0, 1, 1, 0, 8'h44);
      check("f_nogrant", gnt1, 0);
      check("f_cnt0", count, 0);
      cycle(0, 0, 0, 0, 0, '0, 1, 1, 0, 8'h44);
      check("f_gnt1", gnt1, 1);

      // A reset during requester 1's lock abandons the ownership.
      phase = "rst_lock";
      do_reset();
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0, '0, 1, 1, 1, W'(8'h50 + i));
      check("rl_cnt5", count, 5);
      cycle(1, 0, 1, 1, 0, 8'h66, 1, 1, 1, 8'h77);
      check("rl_cnt0", count, 0);
      check("rl_empty", empty, 1);
      check("rl_nog", gnt0 | gnt1, 0);
      cycle(0, 0, 1, 1, 0, 8'h66, 0, 0, 0, '0);
      check("rl_free", gnt0, 1);

      // Randomized traffic, alternating between phases that favour pushes and phases that favour pops.
      phase = "random";
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         push_bias = ((i / 150) % 2) == 0;
         rr  = ($urandom_range(0, 299) == 0);
         ff  = ($urandom_range(0, 59) == 0);
         rq0 = ($urandom_range(0, 9) < 7);
         rq1 = ($urandom_range(0, 9) < 7);
         po0 = push_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         po1 = push_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         lk0 = ($urandom_range(0, 9) < 3);
         lk1 = ($urandom_range(0, 9) < 3);
         cycle(rr, ff, rq0, po0, lk0, W'($urandom), rq1, po1, lk1, W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
